// File: rtl/gen_scan_ctrl.sv
// Raster-scan coordinate generator for a cellular-automaton field.
// Emits each (x,y) cell once per generation and flips the double buffer on completion.
module gen_scan_ctrl #(
    parameter int unsigned FIELD_W    = 32,
    parameter int unsigned FIELD_H    = 15,
    parameter int unsigned GEN_CNT_W  = 16,
    localparam int unsigned X_ADR_SIZE = $clog2(FIELD_W),
    localparam int unsigned Y_ADR_SIZE = $clog2(FIELD_H)
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    input  logic                  i_run,
    input  logic                  i_ready,
    output logic                  o_valid,
    output logic [X_ADR_SIZE-1:0] o_x,
    output logic [Y_ADR_SIZE-1:0] o_y,
    output logic                  o_last,
    output logic                  o_busy,
    output logic                  o_gen_done,
    output logic                  o_buf_sel,
    output logic [GEN_CNT_W-1:0]  o_gen_cnt
);

    // Wrap points come from the field size, not the address width.
    localparam logic [X_ADR_SIZE-1:0] X_LAST = X_ADR_SIZE'(FIELD_W - 1);
    localparam logic [Y_ADR_SIZE-1:0] Y_LAST = Y_ADR_SIZE'(FIELD_H - 1);

    typedef enum logic [1:0] {
        StIdle,
        StScan,
        StDone
    } state_t;

    state_t                r_state;
    logic [X_ADR_SIZE-1:0] r_x;
    logic [Y_ADR_SIZE-1:0] r_y;
    logic                  r_buf_sel;
    logic [GEN_CNT_W-1:0]  r_gen_cnt;

    state_t                w_state_d;
    logic [X_ADR_SIZE-1:0] w_x_d;
    logic [Y_ADR_SIZE-1:0] w_y_d;
    logic                  w_buf_sel_d;
    logic [GEN_CNT_W-1:0]  w_gen_cnt_d;

    logic w_valid;
    logic w_x_end;
    logic w_y_end;
    logic w_last;
    logic w_hs;
    logic w_go;

    assign w_valid = (r_state == StScan);
    assign w_x_end = (r_x == X_LAST);
    assign w_y_end = (r_y == Y_LAST);
    assign w_last  = w_valid & w_x_end & w_y_end;
    assign w_hs    = w_valid & i_ready;
    assign w_go    = i_start | i_run;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state   <= StIdle;
            r_x       <= '0;
            r_y       <= '0;
            r_buf_sel <= 1'b0;
            r_gen_cnt <= '0;
        end else begin
            r_state   <= w_state_d;
            r_x       <= w_x_d;
            r_y       <= w_y_d;
            r_buf_sel <= w_buf_sel_d;
            r_gen_cnt <= w_gen_cnt_d;
        end
    end

    always_comb begin
        w_state_d   = r_state;
        w_x_d       = r_x;
        w_y_d       = r_y;
        w_buf_sel_d = r_buf_sel;
        w_gen_cnt_d = r_gen_cnt;

        unique case (r_state)
            StIdle: begin
                w_x_d = '0;
                w_y_d = '0;
                if (w_go) begin
                    w_state_d = StScan;
                end
            end

            StScan: begin
                // i_start is deliberately not looked at here: no queuing, no restart.
                if (w_hs) begin
                    if (w_last) begin
                        w_state_d   = StDone;
                        w_x_d       = '0;
                        w_y_d       = '0;
                        w_buf_sel_d = ~r_buf_sel;
                        w_gen_cnt_d = r_gen_cnt + GEN_CNT_W'(1);
                    end else if (w_x_end) begin
                        w_x_d = '0;
                        w_y_d = r_y + Y_ADR_SIZE'(1);
                    end else begin
                        w_x_d = r_x + X_ADR_SIZE'(1);
                    end
                end
            end

            StDone: begin
                w_x_d     = '0;
                w_y_d     = '0;
                w_state_d = w_go ? StScan : StIdle;
            end

            default: begin
                w_state_d = StIdle;
                w_x_d     = '0;
                w_y_d     = '0;
            end
        endcase
    end

    assign o_valid    = w_valid;
    assign o_x        = r_x;
    assign o_y        = r_y;
    assign o_last     = w_last;
    assign o_busy     = (r_state != StIdle);
    assign o_gen_done = (r_state == StDone);
    assign o_buf_sel  = r_buf_sel;
    assign o_gen_cnt  = r_gen_cnt;

endmodule

// File: tb/tb_gen_scan_ctrl.sv
// Self-checking bench for gen_scan_ctrl: randomized handshakes checked against a
// cell-index model (x = k mod W, y = k div W) plus a GEN_CNT_W=2 instance for wrap.
module tb_gen_scan_ctrl;

    localparam int W = 32;
    localparam int H = 15;
    localparam int N = W * H;
    localparam int P = N + 1;

    logic clk = 1'b0;
    logic rst_n, start, run, ready;

    logic        valid, last, busy, gen_done, buf_sel;
    logic [4:0]  x;
    logic [3:0]  y;
    logic [15:0] gen_cnt;

    logic        valid2, last2, busy2, gen_done2, buf_sel2;
    logic [4:0]  x2;
    logic [3:0]  y2;
    logic [1:0]  gen_cnt2;

    int n_checks = 0;
    int n_errors = 0;
    int exp_gen  = 0;
    bit exp_buf  = 1'b0;

    always #5 clk = ~clk;

    gen_scan_ctrl #(.FIELD_W(W), .FIELD_H(H), .GEN_CNT_W(16)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_run(run), .i_ready(ready),
        .o_valid(valid), .o_x(x), .o_y(y), .o_last(last), .o_busy(busy),
        .o_gen_done(gen_done), .o_buf_sel(buf_sel), .o_gen_cnt(gen_cnt)
    );

    gen_scan_ctrl #(.FIELD_W(W), .FIELD_H(H), .GEN_CNT_W(2)) dut2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_run(run), .i_ready(ready),
        .o_valid(valid2), .o_x(x2), .o_y(y2), .o_last(last2), .o_busy(busy2),
        .o_gen_done(gen_done2), .o_buf_sel(buf_sel2), .o_gen_cnt(gen_cnt2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        run   = 1'b0;
        start = 1'b0;
        tick();
        rst_n   = 1'b1;
        exp_gen = 0;
        exp_buf = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        run   = 1'b1;
        start = 1'b0;
        ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_checks++;
            if ({valid, x, y, last, busy, gen_done, buf_sel, gen_cnt} !== '0) begin
                n_errors++;
                $display("FAIL reset_outputs cyc%0d: got v=%b x=%0d y=%0d busy=%b done=%b buf=%b cnt=%0d want all 0",
                         i, valid, x, y, busy, gen_done, buf_sel, gen_cnt);
            end
            n_checks++;
            if ({valid2, x2, y2, last2, busy2, gen_done2, buf_sel2, gen_cnt2} !== '0) begin
                n_errors++;
                $display("FAIL reset_outputs_w2 cyc%0d: got v=%b x=%0d y=%0d cnt=%0d want all 0",
                         i, valid2, x2, y2, gen_cnt2);
            end
        end
        rst_n = 1'b1;
        tick();
        n_checks++;
        if (valid !== 1'b1 || x !== 5'd0 || y !== 4'd0 || busy !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_release_first: got v=%b (%0d,%0d) busy=%b want v=1 (0,0) busy=1",
                     valid, x, y, busy);
        end
        do_reset();
        tick();
        n_checks++;
        if (valid !== 1'b0 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_idle: got v=%b busy=%b want 0 0", valid, busy);
        end
    endtask

    // One generation from IDLE via an i_start pulse, random i_ready, optional i_start spam.
    task automatic test_scan_walk(input string tag, input int ready_pct, input bit poke_start);
        int idx;
        idx   = 0;
        run   = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int cyc = 0; cyc < N * 20 && idx < N; cyc++) begin
            n_checks++;
            if (valid !== 1'b1 || busy !== 1'b1 || gen_done !== 1'b0) begin
                n_errors++;
                $display("FAIL %s status k=%0d: got v=%b busy=%b done=%b want 1 1 0",
                         tag, idx, valid, busy, gen_done);
            end
            n_checks++;
            if (x !== 5'(idx % W) || y !== 4'(idx / W)) begin
                n_errors++;
                $display("FAIL %s coord k=%0d: got (%0d,%0d) want (%0d,%0d)",
                         tag, idx, x, y, idx % W, idx / W);
            end
            n_checks++;
            if (last !== (idx == N - 1)) begin
                n_errors++;
                $display("FAIL %s last k=%0d: got %b want %b", tag, idx, last, idx == N - 1);
            end
            ready = ($urandom_range(99) < ready_pct);
            start = poke_start ? ($urandom_range(3) == 0) : 1'b0;
            if (ready) idx++;
            tick();
        end
        start = 1'b0;
        n_checks++;
        if (idx != N) begin
            n_errors++;
            $display("FAIL %s timeout: got %0d handshakes want %0d", tag, idx, N);
        end
        exp_gen++;
        exp_buf = ~exp_buf;
        n_checks++;
        if (valid !== 1'b0 || gen_done !== 1'b1 || x !== 5'd0 || y !== 4'd0) begin
            n_errors++;
            $display("FAIL %s done_cycle: got v=%b done=%b (%0d,%0d) want v=0 done=1 (0,0)",
                     tag, valid, gen_done, x, y);
        end
        n_checks++;
        if (buf_sel !== exp_buf || gen_cnt !== 16'(exp_gen) || gen_cnt2 !== 2'(exp_gen)) begin
            n_errors++;
            $display("FAIL %s gen_state: got buf=%b cnt=%0d cnt2=%0d want buf=%b cnt=%0d cnt2=%0d",
                     tag, buf_sel, gen_cnt, gen_cnt2, exp_buf, exp_gen % 65536, exp_gen % 4);
        end
        tick();
        n_checks++;
        if (busy !== 1'b0 || gen_done !== 1'b0 || valid !== 1'b0) begin
            n_errors++;
            $display("FAIL %s back_to_idle: got busy=%b done=%b v=%b want 0 0 0",
                     tag, busy, gen_done, valid);
        end
    endtask

    task automatic test_continuous(input int gens);
        int done_t[$];
        int phase;
        do_reset();
        ready = 1'b1;
        run   = 1'b1;
        tick();
        for (int t = 0; t < gens * P; t++) begin
            phase = t % P;
            if (t / P == gens - 1 && phase == 100) run = 1'b0;
            if (gen_done === 1'b1) done_t.push_back(t);
            if (phase < N) begin
                n_checks++;
                if (valid !== 1'b1 || x !== 5'(phase % W) || y !== 4'(phase / W)) begin
                    n_errors++;
                    $display("FAIL cont_coord t=%0d: got v=%b (%0d,%0d) want v=1 (%0d,%0d)",
                             t, valid, x, y, phase % W, phase / W);
                end
            end else begin
                exp_gen++;
                exp_buf = ~exp_buf;
                n_checks++;
                if (gen_done !== 1'b1 || buf_sel !== exp_buf || gen_cnt !== 16'(exp_gen)
                    || gen_cnt2 !== 2'(exp_gen)) begin
                    n_errors++;
                    $display("FAIL cont_done t=%0d: got done=%b buf=%b cnt=%0d cnt2=%0d want 1 %b %0d %0d",
                             t, gen_done, buf_sel, gen_cnt, gen_cnt2, exp_buf, exp_gen, exp_gen % 4);
                end
            end
            tick();
        end
        n_checks++;
        if (busy !== 1'b0 || valid !== 1'b0) begin
            n_errors++;
            $display("FAIL cont_stop: got busy=%b v=%b want 0 0", busy, valid);
        end
        n_checks++;
        if (done_t.size() != gens) begin
            n_errors++;
            $display("FAIL cont_pulses: got %0d want %0d", done_t.size(), gens);
        end
        for (int i = 1; i < done_t.size(); i++) begin
            n_checks++;
            if (done_t[i] - done_t[i-1] != P) begin
                n_errors++;
                $display("FAIL cont_period: got %0d want %0d", done_t[i] - done_t[i-1], P);
            end
        end
    endtask

    task automatic test_reset_mid_scan();
        bit found;
        found = 1'b0;
        ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4 * N && !found; i++) begin
            if (x === 5'd5 && y === 4'd3) found = 1'b1;
            else tick();
        end
        n_checks++;
        if (!found) begin
            n_errors++;
            $display("FAIL midrst_reach: got (%0d,%0d) want (5,3)", x, y);
        end
        rst_n = 1'b0;
        tick();
        n_checks++;
        if ({valid, x, y, last, busy, gen_done, buf_sel, gen_cnt} !== '0
            || {gen_done2, buf_sel2, gen_cnt2} !== '0) begin
            n_errors++;
            $display("FAIL midrst_outputs: got v=%b (%0d,%0d) busy=%b done=%b buf=%b cnt=%0d want all 0",
                     valid, x, y, busy, gen_done, buf_sel, gen_cnt);
        end
        rst_n   = 1'b1;
        exp_gen = 0;
        exp_buf = 1'b0;
        tick();
        n_checks++;
        if (gen_done !== 1'b0 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL midrst_no_done: got done=%b busy=%b want 0 0", gen_done, busy);
        end
        test_scan_walk("midrst_restart", 100, 1'b0);
    endtask

    task automatic test_gen_cnt_wrap();
        test_continuous(4);
        n_checks++;
        if (gen_cnt2 !== 2'd0 || buf_sel2 !== 1'b0 || gen_cnt !== 16'd4) begin
            n_errors++;
            $display("FAIL cnt_wrap: got cnt2=%0d buf2=%b cnt=%0d want 0 0 4",
                     gen_cnt2, buf_sel2, gen_cnt);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        run   = 1'b0;
        ready = 1'b0;
        test_reset();
        test_scan_walk("single", 100, 1'b0);
        test_scan_walk("backpressure", 50, 1'b0);
        test_scan_walk("start_in_scan", 80, 1'b1);
        test_continuous(3);
        test_reset_mid_scan();
        test_gen_cnt_wrap();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
